// File: rtl/morse_letter_ctrl.sv
// Groups the Morse symbol stream (dot/dash/gap) into letter entries, detects
// word gaps, and queues {len, code} entries in a small FIFO drained by valid/ready.
module morse_letter_ctrl #(
    parameter int MAX_SYMS   = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_GAP   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sym_tick,
    input  logic [1:0]          sym,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2:0]          out_len,
    output logic [MAX_SYMS-1:0] out_code,
    output logic                sym_err,
    output logic                ovf
);

    localparam int EW = 3 + MAX_SYMS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(WORD_GAP + 1);

    // out_valid means the FIFO head holds an entry; a pop happens on the clock
    // edge where out_valid & out_ready, and the head is held stable until then.

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_GAP,
        S_DISCARD
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_len;
    logic [2:0]          w_len_nxt;
    logic [MAX_SYMS-1:0] r_code;
    logic [MAX_SYMS-1:0] w_code_nxt;
    logic [GW-1:0]       r_gap_cnt;
    logic [GW-1:0]       w_gap_nxt;
    logic [GW-1:0]       w_gap_inc;
    logic                r_sym_err;
    logic                r_ovf;

    logic                w_is_mark;
    logic                w_is_gap;
    logic                w_bit;
    logic [MAX_SYMS-1:0] w_first_code;
    logic                w_push;
    logic [EW-1:0]       w_push_data;
    logic                w_err;

    logic [EW-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [AW:0]         r_count;
    logic                w_pop;
    logic                w_full;
    logic                w_accept;

    assign w_is_mark    = sym_tick && (sym == 2'b01 || sym == 2'b10);
    assign w_is_gap     = sym_tick && (sym == 2'b11);
    assign w_bit        = sym[1];
    assign w_first_code = {{(MAX_SYMS-1){1'b0}}, w_bit};
    assign w_gap_inc    = r_gap_cnt + GW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_code    <= '0;
            r_gap_cnt <= '0;
            r_sym_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len     <= w_len_nxt;
            r_code    <= w_code_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_sym_err <= w_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_code_nxt  = r_code;
        w_gap_nxt   = r_gap_cnt;
        w_push      = 1'b0;
        w_push_data = '0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_mark) begin
                    w_state_nxt = S_COLLECT;
                    w_len_nxt   = 3'd1;
                    w_code_nxt  = w_first_code;
                end
            end
            S_COLLECT: begin
                if (w_is_mark) begin
                    if (r_len == 3'(MAX_SYMS)) begin
                        w_err       = 1'b1;
                        w_len_nxt   = '0;
                        w_code_nxt  = '0;
                        w_state_nxt = S_DISCARD;
                    end else begin
                        w_len_nxt  = r_len + 3'd1;
                        w_code_nxt = {r_code[MAX_SYMS-2:0], w_bit};
                    end
                end else if (w_is_gap) begin
                    w_push      = 1'b1;
                    w_push_data = {r_len, r_code};
                    w_len_nxt   = '0;
                    w_code_nxt  = '0;
                    w_gap_nxt   = GW'(1);
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_is_gap) begin
                    // The closing gap already counted as 1, so silence of
                    // WORD_GAP ticks in total yields exactly one space.
                    if (w_gap_inc == GW'(WORD_GAP)) begin
                        w_push      = 1'b1;
                        w_push_data = '0;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_gap_nxt = w_gap_inc;
                    end
                end else if (w_is_mark) begin
                    w_state_nxt = S_COLLECT;
                    w_len_nxt   = 3'd1;
                    w_code_nxt  = w_first_code;
                    w_gap_nxt   = '0;
                end
            end
            S_DISCARD: begin
                if (w_is_gap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_pop    = out_valid && out_ready;
    assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_accept = w_push && (!w_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wr_ptr] <= w_push_data;
    end

    assign out_valid = (r_count != '0);
    assign out_len   = out_valid ? r_mem[r_rd_ptr][EW-1 -: 3] : '0;
    assign out_code  = out_valid ? r_mem[r_rd_ptr][MAX_SYMS-1:0] : '0;
    assign sym_err   = r_sym_err;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// Scoreboard bench for morse_letter_ctrl: expected entries are queued as letters
// are driven and compared as the consumer accepts them.
module tb_morse_letter_ctrl;

    logic       clk;
    logic       rst;
    logic       sym_tick;
    logic [1:0] sym;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_len;
    logic [4:0] out_code;
    logic       sym_err;
    logic       ovf;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    int         n_pass;
    int         n_total;
    int         n_pops;
    int         n_err;
    int         p0;

    morse_letter_ctrl #(.MAX_SYMS(5), .FIFO_DEPTH(4), .WORD_GAP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sym_tick  (sym_tick),
        .sym       (sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_len   (out_len),
        .out_code  (out_code),
        .sym_err   (sym_err),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic send(input logic [1:0] s);
        @(posedge clk); #1;
        sym_tick = 1'b1;
        sym      = s;
        @(posedge clk); #1;
        sym_tick = 1'b0;
        sym      = 2'b00;
    endtask

    task automatic send_e(input bit expect_it);
        if (expect_it) exp_q.push_back({3'd1, 5'b00000});
        send(2'b01);
        send(2'b11);
    endtask

    task automatic send_t(input bit expect_it);
        if (expect_it) exp_q.push_back({3'd1, 5'b00001});
        send(2'b10);
        send(2'b11);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        chk("drain_done", exp_q.size(), 0);
        @(posedge clk); #1;
        chk("drain_idle", out_valid, 0);
    endtask

    // Consumer side: every accepted entry is matched against the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (sym_err) n_err++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_entry", out_valid, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("entry", {out_len, out_code}, mon_exp);
                    n_pops++;
                end
            end
        end
    end

    initial begin
        n_pass = 0; n_total = 0; n_pops = 0; n_err = 0;
        rst = 1'b1; sym_tick = 1'b0; sym = 2'b00; out_ready = 1'b0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_entry", {out_len, out_code}, 0);
        chk("rst_err", sym_err, 0);
        chk("rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset mid-letter with one entry already queued
        send_e(1'b0);
        send(2'b01);
        send(2'b10);
        chk("pre_rst_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_entry", {out_len, out_code}, 0);
        chk("async_rst_err", sym_err, 0);
        chk("async_rst_ovf", ovf, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(2'b11);
        wait_cycles(3);
        chk("rst_gap_no_push", out_valid, 0);

        // Letter A: dot dash gap
        out_ready = 1'b1;
        exp_q.push_back({3'd2, 5'b00001});
        send(2'b01);
        send(2'b10);
        send(2'b11);
        chk("A_valid", out_valid, 1);
        @(posedge clk); #1;
        chk("A_valid_drop", out_valid, 0);
        chk("A_q_empty", exp_q.size(), 0);

        // Letter B followed by a word gap, then extra silence
        exp_q.push_back({3'd4, 5'b01000});
        exp_q.push_back({3'd0, 5'b00000});
        send(2'b10);
        send(2'b01);
        send(2'b01);
        send(2'b01);
        repeat (4) send(2'b11);
        repeat (3) send(2'b11);
        wait_cycles(2);
        chk("word_q_empty", exp_q.size(), 0);
        chk("word_idle", out_valid, 0);

        // Over-long letter
        repeat (5) send(2'b01);
        chk("long_no_err_yet", sym_err, 0);
        send(2'b01);
        chk("long_err_pulse", sym_err, 1);
        @(posedge clk); #1;
        chk("long_err_clear", sym_err, 0);
        send(2'b11);
        wait_cycles(3);
        chk("long_no_push", out_valid, 0);
        exp_q.push_back({3'd1, 5'b00000});
        send(2'b01);
        send(2'b11);
        wait_cycles(3);
        chk("long_recover_q", exp_q.size(), 0);
        chk("err_pulses", n_err, 1);

        // Back-pressure and overflow
        out_ready = 1'b0;
        send_e(1'b1);
        send_t(1'b1);
        send_e(1'b1);
        send_t(1'b1);
        chk("bp_no_ovf", ovf, 0);
        send_e(1'b0);
        chk("bp_ovf", ovf, 1);
        chk("bp_head", {out_valid, out_len, out_code}, {1'b1, 3'd1, 5'b00000});
        wait_cycles(3);
        chk("bp_head_stable", {out_valid, out_len, out_code}, {1'b1, 3'd1, 5'b00000});
        p0 = n_pops;
        drain();
        chk("bp_drain_count", n_pops - p0, 4);
        chk("bp_ovf_sticky", ovf, 1);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ovf_cleared", ovf, 0);

        // Full FIFO with a pop in the same cycle as the gap push
        out_ready = 1'b0;
        send_e(1'b1);
        send_t(1'b1);
        send_e(1'b1);
        send_t(1'b1);
        exp_q.push_back({3'd1, 5'b00000});
        send(2'b01);
        @(posedge clk); #1;
        sym_tick  = 1'b1;
        sym       = 2'b11;
        out_ready = 1'b1;
        @(posedge clk); #1;
        sym_tick  = 1'b0;
        sym       = 2'b00;
        out_ready = 1'b0;
        chk("simul_no_ovf", ovf, 0);
        p0 = n_pops;
        drain();
        chk("simul_remaining", n_pops - p0, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/morse_letter_ctrl.md
# morse_letter_ctrl

Letter-assembly controller placed after the Morse transition FSM. It consumes that FSM's 2-bit symbol stream (00 none, 01 dot, 10 dash, 11 gap) and groups dots and dashes into letters. It detects word gaps and queues completed letter entries in a small FIFO, which a valid/ready interface drains toward the LCD writer. Over-long letters are rejected and FIFO overflow is flagged.

## Interface
- MAX_SYMS, 5: maximum dots/dashes per letter; code register width equals MAX_SYMS.
- FIFO_DEPTH, 4: letter-entry FIFO depth (power of 2).
- WORD_GAP, 4: consecutive gap ticks (counted from the letter-closing gap) that produce a word space.
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- sym_tick  input  1  one-clk strobe; sym is valid in this cycle.
- sym  input  2  symbol code: 00 none, 01 dot, 10 dash, 11 gap.
- out_valid  output  1  FIFO head entry available.
- out_ready  input  1  consumer accepts head entry when high with out_valid.
- out_len  output  3  symbols in letter; 0 = word space.
- out_code  output  MAX_SYMS  letter pattern, LSB = last symbol, dot=0/dash=1, unused MSBs 0.
- sym_err  output  1  one-cycle pulse: letter exceeded MAX_SYMS.
- ovf  output  1  sticky: an entry was dropped because FIFO full; cleared only by rst.

## Operation
- Inputs are examined only in cycles with sym_tick=1; all other cycles leave state untouched (the FIFO still pops).
- Accumulator: len (3b), code (MAX_SYMS b). A dot or dash performs code <= {code[MAX_SYMS-2:0], bit}, len <= len+1.
- States: IDLE, COLLECT, GAP, DISCARD.
- IDLE: 01/10 -> COLLECT with len=1, code=bit. 00/11 -> stay.
- COLLECT: 01/10 with len<MAX_SYMS -> shift, stay. 01/10 with len==MAX_SYMS -> pulse sym_err, clear accumulator, go to DISCARD. 11 -> push {len,code}, set gap_cnt=1, go to GAP. 00 -> stay.
- GAP: 11 -> gap_cnt+1; when the incremented value equals WORD_GAP, push space {0,0} and go to IDLE. 01/10 -> COLLECT with len=1, code=bit, gap_cnt=0. 00 -> stay, gap_cnt held.
- DISCARD: 11 -> IDLE; no push, word gap not armed. 00/01/10 -> stay.
- Repeated 11 in IDLE produce nothing, so runs of silence create at most one space per word.
- FIFO: push and pop are independent. Full with no pop in the same cycle: entry dropped, ovf<=1. Full with a pop in the same cycle: push accepted. Empty with a simultaneous push: entry is stored; there is no bypass.
- out_len/out_code always reflect the FIFO head. They must stay stable while out_valid=1 and out_ready=0.

## Timing
- Reset, asynchronous: state=IDLE, len=0, code=0, gap_cnt=0, FIFO empty. Outputs: out_valid=0, out_len=0, out_code=0, sym_err=0, ovf=0. Reset mid-letter discards the partial letter and all queued entries.
- Push latency: an entry pushed on the sym_tick cycle N is at the head, with out_valid=1, in cycle N+1 if the FIFO was empty.
- Pop: occurs on the rising edge where out_valid & out_ready. The next entry is presented in the following cycle, or out_valid=0 if the FIFO is now empty.
- sym_err is high exactly during the cycle after the offending sym_tick edge, and low otherwise.
- Throughput: one push per sym_tick maximum; one pop per clk.

## Test plan
- Reset mid-letter: enter dot, dash, then assert rst asynchronously. All outputs go to 0 immediately. A subsequent gap pushes nothing.
- Letter "A": ticks 01,10,11 with out_ready=1. One entry: out_len=2, out_code=00001, out_valid for 1 cycle, starting the cycle after the gap tick.
- Word space: ticks 10,01,01,01 then 11 x4 (WORD_GAP=4). Two entries result: {len=4, code=01000} then {len=0, code=00000}. Further 11 ticks add no entry.
- Over-long letter: six dots, then 11. sym_err pulses once after the 6th tick, and no entry is pushed. Next, 01,11 yields {1,00000}.
- Back-pressure and overflow: out_ready=0, push 5 letters (E,T,E,T,E). FIFO holds 4, ovf=1 after the 5th, and the head stays {1,00000} unchanged. Release out_ready: entries drain in order E,T,E,T and out_valid drops.
- Simultaneous full push/pop: FIFO full, out_ready=1 in the same cycle as a gap push. The entry is accepted, ovf stays 0, and the count stays 4.
